snake_grid_writer: RTL and testbench



---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_grid_writer_if.sv | 37 +++
 rtl/snake_grid_ram.sv | 30 +++
 rtl/snake_grid_writer.sv | 125 ++++++++++++
 tb/tb_snake_grid_writer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the snake grid writer: cell codes, command ops,
// grid/frame geometry and the cell-address helper.
package snake_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int GRID_CELLS = GRID_W * GRID_H;
  localparam int CELL_LOG2  = 4;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int ADDR_W     = 11;
  localparam int CX_W       = 6;
  localparam int CY_W       = 5;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SNAKE = 2'b01;
  localparam logic [1:0] CELL_FOOD  = 2'b10;
  localparam logic [1:0] CELL_WALL  = 2'b11;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_CLEAR = 2'b01,
    OP_NOP_A = 2'b10,
    OP_NOP_B = 2'b11
  } cmd_op_e;

  // Row-major cell address; cy*40 is built from two shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] cx, input logic [5:0] cy);
    logic [ADDR_W-1:0] cx_w;
    logic [ADDR_W-1:0] cy_w;
    cx_w = {{(ADDR_W-6){1'b0}}, cx};
    cy_w = {{(ADDR_W-6){1'b0}}, cy};
    return (cy_w << 5) + (cy_w << 3) + cx_w;
  endfunction

endpackage

// File: rtl/snake_grid_writer_if.sv
`timescale 1ns/1ps
// Command port of the snake grid writer: valid/ready cell commands from the
// game logic plus the busy and error status returned to it.
interface snake_grid_writer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_x;
  logic [4:0] cmd_y;
  logic [1:0] cmd_code;
  logic       busy;
  logic       cmd_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_x,
    output cmd_y,
    output cmd_code,
    input  cmd_ready,
    input  busy,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_x,
    input  cmd_y,
    input  cmd_code,
    output cmd_ready,
    output busy,
    output cmd_err
  );

endinterface

// File: rtl/snake_grid_ram.sv
`timescale 1ns/1ps
// Simple dual-port RAM with one write port and a registered read port;
// a read of the address being written returns the old contents.
module snake_grid_ram #(
  parameter int DEPTH  = 1200,
  parameter int WIDTH  = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Single block keeps read-during-write as old-data, matching block RAM behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/snake_grid_writer.sv
`timescale 1ns/1ps
// Game-side 40x30 cell grid feeding vga_wrapper's game_data/game_enable.
// Define SNAKE_VBLANK_WRITE_EN to accept commands only during vertical blanking.
module snake_grid_writer
  import snake_pkg::*;
(
  input  logic                clock_25,
  input  logic                reset,
  input  logic [9:0]          X,
  input  logic [9:0]          Y,
  output logic [1:0]          game_data,
  output logic                game_enable,
  snake_grid_writer_if.slave  cmd
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              cmd_err_q, cmd_err_d;
  logic              game_enable_q, game_enable_d;
  logic              rd_valid_q, rd_valid_d;

  logic              idle;
  logic              xfer;
  logic              wr_in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic [5:0]        pix_cx;
  logic [5:0]        pix_cy;

  assign idle = (state_q == ST_IDLE);

`ifdef SNAKE_VBLANK_WRITE_EN
  assign cmd.cmd_ready = idle && (Y >= 10'(V_ACTIVE));
`else
  assign cmd.cmd_ready = idle;
`endif

  assign cmd.busy    = !idle;
  assign cmd.cmd_err = cmd_err_q;

  assign xfer        = cmd.cmd_valid && cmd.cmd_ready;
  assign wr_in_range = (cmd.cmd_x < 6'(GRID_W)) && (cmd.cmd_y < 5'(GRID_H));

  // Clear sweep owns the write port; otherwise accepted in-range writes use it.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cmd_err_d  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = clr_addr_q;
    wr_data    = CELL_EMPTY;

    if (state_q == ST_CLEAR) begin
      wr_en = 1'b1;
      if (clr_addr_q == ADDR_W'(GRID_CELLS - 1)) begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
    end else if (xfer) begin
      if (cmd.cmd_op == OP_WRITE) begin
        if (wr_in_range) begin
          wr_en   = 1'b1;
          wr_addr = cell_addr(cmd.cmd_x, {1'b0, cmd.cmd_y});
          wr_data = cmd.cmd_code;
        end else begin
          cmd_err_d = 1'b1;
        end
      end else if (cmd.cmd_op == OP_CLEAR) begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    end
  end

  assign pix_cx  = 6'(X >> CELL_LOG2);
  assign pix_cy  = 6'(Y >> CELL_LOG2);
  assign rd_addr = cell_addr(pix_cx, pix_cy);

  // Blanking addresses alias freely; the registered valid flag masks them to empty.
  always_comb begin
    game_enable_d = (X < 10'(H_ACTIVE)) && (Y < 10'(V_ACTIVE));
    rd_valid_d    = game_enable_d && idle;
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_addr_q    <= '0;
      cmd_err_q     <= 1'b0;
      game_enable_q <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      cmd_err_q     <= cmd_err_d;
      game_enable_q <= game_enable_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  snake_grid_ram #(
    .DEPTH  (GRID_CELLS),
    .WIDTH  (2),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clock_25),
    .wr_en   (wr_en && !reset),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign game_data   = rd_valid_q ? rd_data : CELL_EMPTY;
  assign game_enable = game_enable_q;

endmodule

// File: tb/tb_snake_grid_writer.sv
`timescale 1ns/1ps
// Self-checking bench for snake_grid_writer: randomized commands and pixel scans
// against a behavioural grid model; define SNAKE_VBLANK_WRITE_EN to match the DUT build.
module tb_snake_grid_writer;
  import snake_pkg::*;

  logic       clock_25 = 1'b0;
  logic       reset    = 1'b1;
  logic [9:0] X        = '0;
  logic [9:0] Y        = '0;
  logic [1:0] game_data;
  logic       game_enable;

  int n_checks = 0;
  int n_fail   = 0;

  snake_grid_writer_if cmd_bus();

  snake_grid_writer dut (
    .clock_25    (clock_25),
    .reset       (reset),
    .X           (X),
    .Y           (Y),
    .game_data   (game_data),
    .game_enable (game_enable),
    .cmd         (cmd_bus)
  );

  always #20 clock_25 = ~clock_25;

  // Behavioural model: grid contents, remaining clear cycles, expected registered outputs.
  logic [1:0] m_mem [GRID_CELLS];
  int         m_clear_left = 0;
  logic [1:0] m_gd  = 2'b00;
  bit         m_ge  = 1'b0;
  bit         m_err = 1'b0;
  bit         m_on  = 1'b0;

  function automatic bit model_ready();
    bit rdy;
    rdy = (m_clear_left == 0);
`ifdef SNAKE_VBLANK_WRITE_EN
    rdy = rdy && (int'(Y) >= V_ACTIVE);
`endif
    return rdy;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clock_25) begin
    if (reset) begin
      m_clear_left = GRID_CELLS;
      m_gd         = CELL_EMPTY;
      m_ge         = 1'b0;
      m_err        = 1'b0;
      m_on         = 1'b1;
    end else if (m_on) begin
      int  px, py, cx, cy;
      bit  xfer;
      px   = int'(X);
      py   = int'(Y);
      cx   = int'(cmd_bus.cmd_x);
      cy   = int'(cmd_bus.cmd_y);
      xfer = cmd_bus.cmd_valid && model_ready();
      m_ge = (px < H_ACTIVE) && (py < V_ACTIVE);
      m_gd = CELL_EMPTY;
      if (m_ge && m_clear_left == 0) begin
        m_gd = m_mem[(py >> CELL_LOG2) * GRID_W + (px >> CELL_LOG2)];
      end
      m_err = xfer && (cmd_bus.cmd_op == OP_WRITE) && (cx >= GRID_W || cy >= GRID_H);
      if (m_clear_left > 0) begin
        m_mem[GRID_CELLS - m_clear_left] = CELL_EMPTY;
        m_clear_left--;
      end else if (xfer && cmd_bus.cmd_op == OP_WRITE && !m_err) begin
        m_mem[cy * GRID_W + cx] = cmd_bus.cmd_code;
      end else if (xfer && cmd_bus.cmd_op == OP_CLEAR) begin
        m_clear_left = GRID_CELLS;
      end
    end
  end

  always @(negedge clock_25) begin
    if (m_on) begin
      checkOutput("game_data",   int'(game_data),         int'(m_gd));
      checkOutput("game_enable", int'(game_enable),       int'(m_ge));
      checkOutput("cmd_err",     int'(cmd_bus.cmd_err),   int'(m_err));
      checkOutput("busy",        int'(cmd_bus.busy),      int'(m_clear_left > 0));
      checkOutput("cmd_ready",   int'(cmd_bus.cmd_ready), int'(model_ready()));
    end
  end

  task automatic tick();
    @(posedge clock_25);
    #2;
  endtask

  task automatic applyStimulus(input bit v, input int op, input int x, input int y, input int code);
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = 2'(op);
    cmd_bus.cmd_x     = 6'(x);
    cmd_bus.cmd_y     = 5'(y);
    cmd_bus.cmd_code  = 2'(code);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (cmd_bus.busy && n < 2000) begin
      X = 10'($urandom_range(0, 1023));
      Y = 10'($urandom_range(0, 1023));
      tick();
      n++;
    end
  endtask

  initial begin
    #3_600_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < GRID_CELLS; i++) m_mem[i] = CELL_EMPTY;
    applyStimulus(1'b0, 0, 0, 0, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_busy",   int'(cmd_bus.busy),      1);
    checkOutput("rst_ready",  int'(cmd_bus.cmd_ready), 0);
    checkOutput("rst_err",    int'(cmd_bus.cmd_err),   0);
    checkOutput("rst_gdata",  int'(game_data),         0);
    checkOutput("rst_genab",  int'(game_enable),       0);
    countBusy(n);
    checkOutput("init_clear_len", n, 1200);

`ifdef SNAKE_VBLANK_WRITE_EN
    X = 10'd0; Y = 10'd100;
    #1;
    checkOutput("vb_ready_active", int'(cmd_bus.cmd_ready), 0);
    Y = 10'd480;
    #1;
    checkOutput("vb_ready_blank", int'(cmd_bus.cmd_ready), 1);
    applyStimulus(1'b1, OP_WRITE, 5, 3, 1);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 0);
    X = 10'd80; Y = 10'd48;
    tick();
    checkOutput("vb_write_read", int'(game_data), 1);
`else
    applyStimulus(1'b1, OP_WRITE, 5, 3, 1);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 0);
    for (int py = 48; py < 64; py++) begin
      for (int px = 80; px < 96; px++) begin
        X = 10'(px); Y = 10'(py);
        tick();
        checkOutput("cell_5_3", int'(game_data), 1);
      end
    end
    X = 10'd96; Y = 10'd48;
    tick();
    checkOutput("cell_6_3", int'(game_data), 0);

    applyStimulus(1'b1, OP_WRITE, 40, 0, 2);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 0);
    X = 10'd0; Y = 10'd16;
    checkOutput("err_pulse", int'(cmd_bus.cmd_err), 1);
    tick();
    checkOutput("err_drop", int'(cmd_bus.cmd_err), 0);
    checkOutput("err_no_alias", int'(game_data), 0);

    applyStimulus(1'b1, OP_WRITE, 39, 29, 3);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 0);
    X = 10'd624; Y = 10'd464;
    tick();
    checkOutput("corner_39_29", int'(game_data), 3);

    X = 10'd32; Y = 10'd32;
    applyStimulus(1'b1, OP_WRITE, 2, 2, 2);
    tick();
    checkOutput("rdw_old", int'(game_data), 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    tick();
    checkOutput("rdw_new", int'(game_data), 2);
`endif

    X = 10'd700; Y = 10'd100;
    tick();
    checkOutput("blank_x_en",   int'(game_enable), 0);
    checkOutput("blank_x_data", int'(game_data),   0);
    X = 10'd80; Y = 10'd500;
    tick();
    checkOutput("blank_y_en",   int'(game_enable), 0);
    checkOutput("blank_y_data", int'(game_data),   0);

    for (int i = 0; i < 800; i++) begin
      int r;
      int op;
      r  = int'($urandom_range(0, 99));
      op = (r < 1) ? OP_CLEAR : (r < 8) ? int'($urandom_range(2, 3)) : OP_WRITE;
      applyStimulus(($urandom_range(0, 2) != 0),
                    op,
                    ((r % 10) == 9) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39)),
                    ((r % 10) == 8) ? int'($urandom_range(30, 31)) : int'($urandom_range(0, 29)),
                    int'($urandom_range(0, 3)));
      X = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 639));
      Y = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 479));
`ifdef SNAKE_VBLANK_WRITE_EN
      if ($urandom_range(0, 1) == 1) Y = 10'($urandom_range(480, 524));
`endif
      tick();
    end

    applyStimulus(1'b0, 0, 0, 0, 0);
    X = 10'd0; Y = 10'd480;
    n = 0;
    while (!cmd_bus.cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("idle_before_clear", int'(cmd_bus.cmd_ready), 1);

    applyStimulus(1'b1, OP_WRITE, 1, 1, 3);
    tick();
    applyStimulus(1'b1, OP_WRITE, 10, 10, 2);
    tick();
    applyStimulus(1'b1, OP_CLEAR, 0, 0, 0);
    tick();
    applyStimulus(1'b1, OP_WRITE, 7, 7, 1);
    checkOutput("clr_busy",  int'(cmd_bus.busy),      1);
    checkOutput("clr_ready", int'(cmd_bus.cmd_ready), 0);
    n = 0;
    while (!cmd_bus.cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("clear_len", n, 1200);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 0);
    for (int cy = 0; cy < GRID_H; cy++) begin
      for (int cx = 0; cx < GRID_W; cx++) begin
        X = 10'(cx * 16 + int'($urandom_range(0, 15)));
        Y = 10'(cy * 16 + int'($urandom_range(0, 15)));
        tick();
        checkOutput("after_clear", int'(game_data), (cx == 7 && cy == 7) ? 1 : 0);
      end
    end

    applyStimulus(1'b1, OP_CLEAR, 0, 0, 0);
    tick();
    applyStimulus(1'b1, OP_WRITE, 3, 3, 3);
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("midclr_rst_busy", int'(cmd_bus.busy), 1);
    countBusy(n);
    checkOutput("midclr_rst_len", n, 1200);
    X = 10'd48; Y = 10'd48;
    tick();
    checkOutput("midclr_cell_3_3", int'(game_data), 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
